mem_arbiter: RTL

Sequences the single shared memory port between the instruction-fetch path and the load/store path of the RISC-V core. Each requester presents one word transaction at a time with a req/gnt/ack handshake. The arbiter selects one winner, drives the memory port for one cycle and waits a fixed read latency. It then returns the response to the winner only. It sits between the core datapath (PC/fetch and ALU/LSU) and the unified memory, so the memory can move from combinational to synchronous read.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arbiter_if.sv | 59 +++++
 rtl/mem_arb_sel.sv | 40 ++++
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the fetch/load-store memory
//               arbiter: FSM state encoding, requester IDs, counter width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Requester identifiers, also used as the round-robin pointer value
  localparam logic ARB_ID_I = 1'b0;
  localparam logic ARB_ID_D = 1'b1;

  // Latency counter width; covers MEM_LATENCY-1 for MEM_LATENCY up to 7
  localparam int CNT_W = 3;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of the fetch port, load/store port and shared memory
//               port seen by the arbiter. The slave modport is the arbiter's
//               view; the master modport is the core + memory side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);

  // Instruction-fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_ack;
  logic [31:0]       i_rdata;

  // Load/store requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_wstrb;
  logic              d_gnt;
  logic              d_ack;
  logic [31:0]       d_rdata;

  // Shared memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_ack, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_gnt, d_ack, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_ack, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_gnt, d_ack, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata
  );

endinterface

`default_nettype wire

// File: rtl/mem_arb_sel.sv
// ============================================================================
// Module      : mem_arb_sel
// Description : Combinational winner select between fetch and data requests.
//               Build option ARB_ROUND_ROBIN_EN: when defined, a tie goes to
//               the requester named by ptr_i; when undefined, data always
//               wins a tie and there is no pointer input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_sel
  import mem_arb_pkg::*;
(
  input  logic i_req_i,
  input  logic d_req_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic ptr_i,
`endif
  output logic valid_o,
  output logic id_o
);

  // Pick a winner; only the tie case depends on the build option
  always_comb begin
    valid_o = i_req_i | d_req_i;
    id_o    = ARB_ID_I;
    if (d_req_i && !i_req_i) begin
      id_o = ARB_ID_D;
    end else if (d_req_i && i_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      id_o = ptr_i;
`else
      id_o = ARB_ID_D;
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one synchronous-read memory port between the fetch
//               and load/store paths. One transaction in flight at a time:
//               IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> RESP -> IDLE.
//               Build option ARB_ROUND_ROBIN_EN selects round-robin tie
//               breaking; otherwise data has fixed priority over fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 1,   // legal range 1..7
  parameter int ADDR_W      = 32
) (
  input  logic          clk,
  input  logic          rst,       // synchronous, active-low
  mem_arbiter_if.slave  bus
);

  // Value loaded into the latency counter when leaving ISSUE
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY - 1);

  arb_state_e         state_q;
  logic               win_id_q;
  logic               win_we_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               i_gnt_q;
  logic               i_ack_q;
  logic [31:0]        i_rdata_q;
  logic               d_gnt_q;
  logic               d_ack_q;
  logic [31:0]        d_rdata_q;

  logic               mem_en_q;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [31:0]        mem_wdata_q;
  logic [3:0]         mem_wstrb_q;

  logic               sel_valid;
  logic               sel_id;

`ifdef ARB_ROUND_ROBIN_EN
  logic               ptr_q;       // requester favoured on the next tie
`endif

  mem_arb_sel u_sel (
    .i_req_i (bus.i_req),
    .d_req_i (bus.d_req),
`ifdef ARB_ROUND_ROBIN_EN
    .ptr_i   (ptr_q),
`endif
    .valid_o (sel_valid),
    .id_o    (sel_id)
  );

  // Arbiter FSM with registered outputs. Pulses (gnt, ack, mem_*) default to
  // 0 each cycle and are set on the edge entering the state that shows them.
  // WAIT always spans MEM_LATENCY cycles so its last cycle is the one in
  // which mem_rdata is valid; that word is captured straight into rdata.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      win_id_q    <= ARB_ID_I;
      win_we_q    <= 1'b0;
      cnt_q       <= '0;
      i_gnt_q     <= 1'b0;
      i_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_gnt_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q       <= ARB_ID_D;
`endif
    end else begin
      i_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;

      case (state_q)
        IDLE: begin
          if (sel_valid) begin
            state_q  <= ISSUE;
            win_id_q <= sel_id;
            mem_en_q <= 1'b1;
            if (sel_id == ARB_ID_D) begin
              d_gnt_q     <= 1'b1;
              win_we_q    <= bus.d_we;
              mem_we_q    <= bus.d_we;
              mem_addr_q  <= bus.d_addr;
              // Reads drive no write data and no byte enables
              mem_wdata_q <= bus.d_we ? bus.d_wdata : 32'h0;
              mem_wstrb_q <= bus.d_we ? bus.d_wstrb : 4'b0000;
            end else begin
              i_gnt_q     <= 1'b1;
              win_we_q    <= 1'b0;
              mem_addr_q  <= bus.i_addr;
            end
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q <= ~sel_id;
`endif
          end
        end

        ISSUE: begin
          cnt_q   <= LAT_LOAD;
          state_q <= WAIT;
        end

        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
            if (win_id_q == ARB_ID_D) begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= win_we_q ? 32'h0 : bus.mem_rdata;
            end else begin
              i_ack_q   <= 1'b1;
              i_rdata_q <= bus.mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        RESP: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.i_gnt     = i_gnt_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;

endmodule

`default_nettype wire
